pipeline_flow_ctrl: RTL

PIPELINE_FLOW_CTRL -- requirements
Module: pipeline_flow_ctrl

---
 rtl/pipeline_flow_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipeline_flow_ctrl.sv
// rtl/pipeline_flow_ctrl.sv - valid tracking and 2-entry skid buffer controlling an enable-gated datapath
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous clear of in-flight items and buffered results
//   in_valid, in_ready   upstream operand handshake (in_ready == en)
//   en                   advance enable for every external datapath stage register
//   pipe_data            result at the datapath's last stage
//   out_valid, out_ready downstream result handshake
//   out_data             oldest buffered result
//   occupancy            valid items in the pipeline plus the buffer
module pipeline_flow_ctrl #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             en,
    input  logic [WIDTH-1:0]                 pipe_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(LATENCY+3)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(LATENCY + 3);

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] vld_next;
    logic [1:0]         buf_cnt;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [WIDTH-1:0]   mem [2];
    logic               push;
    logic               pop;

    // The pipeline only stalls when a result is waiting at the last stage
    // and there is nowhere to put it. Deliberately independent of out_ready
    // so no combinational path runs from downstream back to upstream.
    assign en        = !(vld[LATENCY-1] && (buf_cnt == 2'd2)) && !flush;
    assign in_ready  = en;
    assign push      = en && vld[LATENCY-1];
    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        vld_next    = '0;
        vld_next[0] = in_valid;
        for (int k = 1; k < LATENCY; k++) begin
            vld_next[k] = vld[k-1];
        end
    end

    always_comb begin
        occupancy = OCC_W'(buf_cnt);
        for (int k = 0; k < LATENCY; k++) begin
            occupancy = occupancy + OCC_W'(vld[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            buf_cnt <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else if (flush) begin
            vld     <= '0;
            buf_cnt <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            if (en) begin
                vld <= vld_next;
            end
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Result storage carries no reset; out_data is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pipe_data;
        end
    end

endmodule
